// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter
// and its round-robin picker.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int DW_DEF = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int m);
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Round-robin pick: rotate by ptr, priority-encode the lowest
// set bit, then un-rotate back to a producer index.
module fifo_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any_req,
  output logic [IW-1:0] pick
);

  logic [N-1:0]  rot;
  logic [IW-1:0] k;

  always_comb begin
    rot = '0;
    k   = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req[(int'(ptr) + i) % N];
    end
    // Descending scan leaves the lowest set offset in k.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) k = IW'(i);
    end
    pick    = IW'((int'(k) + int'(ptr)) % N);
    any_req = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among
// N_REQ producers; zero-latency data mux, registered control.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int DW        = DW_DEF,
  parameter  int MAX_BURST = 4,
  localparam int IW        = idx_w(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  input  logic [N_REQ-1:0]    req_last,
  output logic [N_REQ-1:0]    req_ready,
  output logic                fifo_wr,
  output logic [DW-1:0]       fifo_din,
  input  logic                fifo_full,
  output logic [IW-1:0]       grant_id,
  output logic                busy
);

  localparam int CW = cnt_w(MAX_BURST);

  state_e        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [IW-1:0] nxt_owner;
  logic [IW-1:0] pick;
  logic          any_req;
  logic          xfer;
  logic          rel;
  logic [DW-1:0] data_a [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_data
    assign data_a[i] = req_data[i*DW +: DW];
  end

  fifo_rr_pick #(
    .N (N_REQ)
  ) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .any_req (any_req),
    .pick    (pick)
  );

  assign nxt_owner = (owner_q == IW'(N_REQ - 1))
                   ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    req_ready  = '0;
    fifo_wr    = 1'b0;
    fifo_din   = '0;
    xfer       = 1'b0;
    rel        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d    = pick;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        req_ready[owner_q] = !fifo_full;
        xfer = req_valid[owner_q] & !fifo_full;
        fifo_wr = xfer;
        if (xfer) fifo_din = data_a[owner_q];
        if (xfer) beat_cnt_d = beat_cnt_q + 1'b1;
        // Abandon only counts when the FIFO could have taken a beat.
        rel = (xfer & req_last[owner_q])
            | (xfer & (beat_cnt_q == CW'(MAX_BURST - 1)))
            | (!req_valid[owner_q] & !fifo_full);
        if (rel) begin
          state_d    = IDLE;
          rr_ptr_d   = nxt_owner;
          beat_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign grant_id = owner_q;
  assign busy     = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: N_REQ=4, DW=8, MAX_BURST=4.
// Observed vector is {busy, grant_id, req_ready, fifo_wr, fifo_din}.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        fifo_wr;
  logic [7:0]  fifo_din;
  logic        fifo_full;
  logic [1:0]  grant_id;
  logic        busy;

  logic [15:0] obs;
  int          n_pass;
  int          n_total;
  int          wr_total;

  fifo_wr_arbiter #(
    .N_REQ     (4),
    .DW        (8),
    .MAX_BURST (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .fifo_wr   (fifo_wr),
    .fifo_din  (fifo_din),
    .fifo_full (fifo_full),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  assign obs = {busy, grant_id, req_ready, fifo_wr, fifo_din};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (fifo_wr) wr_total++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    fifo_full = 1'b0;
    #1;
    n_total++;
    if (obs !== 16'h0) $display("FAIL reset_async obs=%h exp=%h", obs, 16'h0);
    else n_pass++;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_total++;
    if (obs !== 16'h0) $display("FAIL reset_release obs=%h exp=%h", obs, 16'h0);
    else n_pass++;
  endtask

  task automatic test_single();
    logic [15:0] e;
    req_valid = 4'b0001;
    req_data[7:0] = 8'hAA;
    #1;
    n_total++;
    if (obs !== 16'h0) $display("FAIL single_idle obs=%h exp=%h", obs, 16'h0);
    else n_pass++;
    tick();
    e = {1'b1, 2'd0, 4'b0001, 1'b1, 8'hAA};
    n_total++;
    if (obs !== e) $display("FAIL single_b0 obs=%h exp=%h", obs, e);
    else n_pass++;
    tick();
    req_data[7:0] = 8'hBB;
    #1;
    e = {1'b1, 2'd0, 4'b0001, 1'b1, 8'hBB};
    n_total++;
    if (obs !== e) $display("FAIL single_b1 obs=%h exp=%h", obs, e);
    else n_pass++;
    tick();
    req_data[7:0] = 8'hCC;
    req_last = 4'b0001;
    #1;
    e = {1'b1, 2'd0, 4'b0001, 1'b1, 8'hCC};
    n_total++;
    if (obs !== e) $display("FAIL single_b2 obs=%h exp=%h", obs, e);
    else n_pass++;
    tick();
    req_valid = '0;
    req_last = '0;
    #1;
    n_total++;
    if (obs !== 16'h0) $display("FAIL single_release obs=%h exp=%h", obs, 16'h0);
    else n_pass++;
  endtask

  // rr_ptr is 1 after the single burst, so rotation starts at 1.
  task automatic test_rotate();
    logic [15:0] e;
    int o;
    int prev;
    prev = 0;
    req_valid = 4'b1111;
    req_last = '0;
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int g = 0; g < 5; g++) begin
      o = (1 + g) % 4;
      #1;
      e = {1'b0, 2'(prev), 4'b0000, 1'b0, 8'h00};
      n_total++;
      if (obs !== e) $display("FAIL rot_bubble g=%0d obs=%h exp=%h", g, obs, e);
      else n_pass++;
      tick();
      for (int b = 0; b < 4; b++) begin
        e = {1'b1, 2'(o), 4'(1 << o), 1'b1, 8'hA0 + 8'(o)};
        n_total++;
        if (obs !== e) $display("FAIL rot_beat g=%0d b=%0d obs=%h exp=%h", g, b, obs, e);
        else n_pass++;
        tick();
      end
      prev = o;
    end
  endtask

  task automatic test_full_stall();
    logic [15:0] e;
    int w0;
    w0 = wr_total;
    req_valid = 4'b0100;
    req_data[23:16] = 8'h21;
    #1;
    e = {1'b0, 2'd1, 4'b0000, 1'b0, 8'h00};
    n_total++;
    if (obs !== e) $display("FAIL full_idle obs=%h exp=%h", obs, e);
    else n_pass++;
    tick();
    e = {1'b1, 2'd2, 4'b0100, 1'b1, 8'h21};
    n_total++;
    if (obs !== e) $display("FAIL full_b1 obs=%h exp=%h", obs, e);
    else n_pass++;
    tick();
    req_data[23:16] = 8'h22;
    #1;
    e = {1'b1, 2'd2, 4'b0100, 1'b1, 8'h22};
    n_total++;
    if (obs !== e) $display("FAIL full_b2 obs=%h exp=%h", obs, e);
    else n_pass++;
    tick();
    fifo_full = 1'b1;
    req_data[23:16] = 8'h23;
    for (int s = 0; s < 3; s++) begin
      #1;
      e = {1'b1, 2'd2, 4'b0000, 1'b0, 8'h00};
      n_total++;
      if (obs !== e) $display("FAIL full_stall s=%0d obs=%h exp=%h", s, obs, e);
      else n_pass++;
      tick();
    end
    fifo_full = 1'b0;
    #1;
    e = {1'b1, 2'd2, 4'b0100, 1'b1, 8'h23};
    n_total++;
    if (obs !== e) $display("FAIL full_b3 obs=%h exp=%h", obs, e);
    else n_pass++;
    tick();
    req_data[23:16] = 8'h24;
    #1;
    e = {1'b1, 2'd2, 4'b0100, 1'b1, 8'h24};
    n_total++;
    if (obs !== e) $display("FAIL full_b4 obs=%h exp=%h", obs, e);
    else n_pass++;
    tick();
    req_valid = '0;
    #1;
    e = {1'b0, 2'd2, 4'b0000, 1'b0, 8'h00};
    n_total++;
    if (obs !== e) $display("FAIL full_release obs=%h exp=%h", obs, e);
    else n_pass++;
    n_total++;
    if (wr_total - w0 !== 4) $display("FAIL full_wr_count got=%0d exp=4", wr_total - w0);
    else n_pass++;
  endtask

  task automatic test_abandon_rr();
    logic [15:0] e;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 4'b1010;
    req_data = {8'h73, 8'h00, 8'h51, 8'h00};
    req_last = 4'b1000;
    #1;
    n_total++;
    if (obs !== 16'h0) $display("FAIL ab_idle obs=%h exp=%h", obs, 16'h0);
    else n_pass++;
    tick();
    e = {1'b1, 2'd1, 4'b0010, 1'b1, 8'h51};
    n_total++;
    if (obs !== e) $display("FAIL ab_p1_beat obs=%h exp=%h", obs, e);
    else n_pass++;
    tick();
    req_valid = 4'b1000;
    #1;
    e = {1'b1, 2'd1, 4'b0010, 1'b0, 8'h00};
    n_total++;
    if (obs !== e) $display("FAIL ab_p1_drop obs=%h exp=%h", obs, e);
    else n_pass++;
    tick();
    req_valid = 4'b1010;
    #1;
    e = {1'b0, 2'd1, 4'b0000, 1'b0, 8'h00};
    n_total++;
    if (obs !== e) $display("FAIL ab_release obs=%h exp=%h", obs, e);
    else n_pass++;
    tick();
    e = {1'b1, 2'd3, 4'b1000, 1'b1, 8'h73};
    n_total++;
    if (obs !== e) $display("FAIL ab_p3_grant obs=%h exp=%h", obs, e);
    else n_pass++;
    tick();
    e = {1'b0, 2'd3, 4'b0000, 1'b0, 8'h00};
    n_total++;
    if (obs !== e) $display("FAIL ab_p3_release obs=%h exp=%h", obs, e);
    else n_pass++;
    tick();
    req_last = 4'b1010;
    #1;
    e = {1'b1, 2'd1, 4'b0010, 1'b1, 8'h51};
    n_total++;
    if (obs !== e) $display("FAIL ab_p1_regrant obs=%h exp=%h", obs, e);
    else n_pass++;
    tick();
    req_valid = '0;
    req_last = '0;
    #1;
    e = {1'b0, 2'd1, 4'b0000, 1'b0, 8'h00};
    n_total++;
    if (obs !== e) $display("FAIL ab_final obs=%h exp=%h", obs, e);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [15:0] e;
    req_valid = 4'b0101;
    req_data = {8'h00, 8'h2F, 8'h00, 8'h0F};
    tick();
    e = {1'b1, 2'd2, 4'b0100, 1'b1, 8'h2F};
    n_total++;
    if (obs !== e) $display("FAIL ar_p2_grant obs=%h exp=%h", obs, e);
    else n_pass++;
    #3;
    rst = 1'b1;
    #1;
    n_total++;
    if (obs !== 16'h0) $display("FAIL ar_immediate obs=%h exp=%h", obs, 16'h0);
    else n_pass++;
    tick();
    n_total++;
    if (obs !== 16'h0) $display("FAIL ar_held obs=%h exp=%h", obs, 16'h0);
    else n_pass++;
    rst = 1'b0;
    tick();
    e = {1'b1, 2'd0, 4'b0001, 1'b1, 8'h0F};
    n_total++;
    if (obs !== e) $display("FAIL ar_p0_grant obs=%h exp=%h", obs, e);
    else n_pass++;
    req_valid = '0;
    tick();
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    wr_total = 0;
    test_reset();
    test_single();
    test_rotate();
    test_full_stall();
    test_abandon_rr();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout obs=%h exp=finish", obs);
    $fatal(1, "timeout");
  end

endmodule
